// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI definitions for the mode-0 responder and spi_master
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    localparam int SPI_DATA_W_DEF = 8;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/sync2_edge.sv
// sync2_edge: two-flop synchroniser plus a history flop giving level, rise and fall
module sync2_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // two metastability stages, the third stage remembers the previous synced level
    always_ff @(posedge clk) begin
        if (!rst) sync_q <= {3{RST_VAL}};
        else      sync_q <= {sync_q[1:0], d_i};
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 responder; optional sticky overrun flag via SPI_SLAVE_OVERRUN_EN
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int              DATA_W  = SPI_DATA_W_DEF,
    parameter logic [DATA_W-1:0] IDLE_TX = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err
`ifdef SPI_SLAVE_OVERRUN_EN
   ,output logic              ovr
`endif
);

    localparam int              CW        = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DATA_W);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DATA_W - 1);
    localparam logic            LEAD_FALL = SPI_CPOL ^ SPI_CPHA;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sclk_lead, sclk_trail;
    logic unused_edges;

    sync2_edge #(.RST_VAL(SPI_CPOL)) u_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync2_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d_i(ss),
        .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    sync2_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d_i(mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};
    assign sclk_lead    = LEAD_FALL ? sclk_fall : sclk_rise;
    assign sclk_trail   = LEAD_FALL ? sclk_rise : sclk_fall;

    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic              ovr_q, ovr_d;
`endif

    // state and datapath registers; every register returns to its idle value on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= IDLE_TX;
            rx_sr_q     <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            ovr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rx_sr_q     <= rx_sr_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_SLAVE_OVERRUN_EN
            ovr_q       <= ovr_d;
`endif
        end
    end

    // next state: frame sequencing, bit shifting, word delivery and reply buffering
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        rx_sr_d     = rx_sr_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        ovr_d       = ovr_q;
`endif
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (done_q) begin
`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_valid_q && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
            end
`else
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
`endif
        end
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d   = tx_full_q ? tx_buf_q : IDLE_TX;
                tx_full_d = 1'b0;
                bit_cnt_d = '0;
                state_d   = ss_rise ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0) && (bit_cnt_q < CNT_FULL);
                end else if (sclk_lead) begin
                    rx_sr_d   = {rx_sr_q[DATA_W-2:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    done_d    = (bit_cnt_q == CNT_LAST);
                end else if (sclk_trail) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        shreg_d   = tx_full_q ? tx_buf_q : IDLE_TX;
                        tx_full_d = 1'b0;
                        bit_cnt_d = '0;
                    end else begin
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // a handshake in the same cycle as a reload lands in the freshly emptied buffer
        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    assign miso      = (state_q == ST_IDLE) ? 1'b1 : shreg_q[DATA_W-1];
    assign miso_oe   = (state_q != ST_IDLE) && !ss_lvl;
    assign tx_ready  = !tx_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign ovr       = ovr_q;
`endif

endmodule
